// File: rtl/pll_phase_tuner_pkg.sv
// Shared types for the PLL phase tuner: sequencer states, step-generator
// segments, the calibration result record and the phase-index width helper.
package tuner_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TEST,
        S_EVAL,
        S_STEP_HI,
        S_STEP_LO,
        S_SETTLE,
        S_RESOLVE,
        S_CENTER,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEG_IDLE,
        SEG_HI,
        SEG_LO,
        SEG_SETTLE
    } step_seg_t;

    // Widest phase index the result record can carry; instances slice it down.
    localparam int MAX_PW = 16;

    typedef struct packed {
        logic [MAX_PW-1:0] best_phase;
        logic [MAX_PW:0]   window_len;
        logic              fail;
    } result_t;

    function automatic int calc_pw(input int steps);
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/pll_phase_tuner_if.sv
// Control, PLL phase-shift and capture-test signals of the phase tuner.
// The tuner is the master; the PLL wrapper / training logic side is the slave.
interface pll_phase_tuner_if
    import tuner_pkg::*;
#(
    parameter int PS_STEPS = 64
);
    localparam int PW = calc_pw(PS_STEPS);

    logic          pll_lock;
    logic          start;
    logic          busy;
    logic          done;
    logic          fail;
    logic [2:0]    ps_sel;
    logic          ps_dir;
    logic          ps_pulse;
    logic          test_req;
    logic          test_ack;
    logic          test_pass;
    logic [PW-1:0] best_phase;
    logic [PW:0]   window_len;

    modport master (
        input  pll_lock, start, test_ack, test_pass,
        output busy, done, fail, ps_sel, ps_dir, ps_pulse, test_req,
               best_phase, window_len
    );

    modport slave (
        output pll_lock, start, test_ack, test_pass,
        input  busy, done, fail, ps_sel, ps_dir, ps_pulse, test_req,
               best_phase, window_len
    );

endinterface

// File: rtl/pll_phase_tuner_ps_step_gen.sv
// One PLL phase step: ps_pulse high then low for PULSE_WIDTH cycles each,
// followed by SETTLE_CYCLES of quiet time; strobes mark the end of each segment.
module ps_step_gen
    import tuner_pkg::*;
#(
    parameter int PULSE_WIDTH   = 4,
    parameter int SETTLE_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_go,
    input  logic dir,
    input  logic abort,
    output logic ps_pulse,
    output logic ps_dir,
    output logic hi_end,
    output logic lo_end,
    output logic step_done
);

    localparam int CMAX = (PULSE_WIDTH > SETTLE_CYCLES) ? PULSE_WIDTH : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    step_seg_t     seg_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] last_cnt;
    logic          seg_last;

    always_comb begin
        last_cnt  = (seg_q == SEG_SETTLE) ? CW'(SETTLE_CYCLES - 1) : CW'(PULSE_WIDTH - 1);
        seg_last  = (cnt_q == last_cnt);
        hi_end    = (seg_q == SEG_HI) && seg_last;
        lo_end    = (seg_q == SEG_LO) && seg_last;
        step_done = (seg_q == SEG_SETTLE) && seg_last;
    end

    // ps_pulse and ps_dir are flops so the PLL port never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= SEG_IDLE;
            cnt_q    <= '0;
            ps_pulse <= 1'b0;
            ps_dir   <= 1'b0;
        end else if (abort) begin
            seg_q    <= SEG_IDLE;
            cnt_q    <= '0;
            ps_pulse <= 1'b0;
        end else if (step_go) begin
            seg_q    <= SEG_HI;
            cnt_q    <= '0;
            ps_pulse <= 1'b1;
            ps_dir   <= dir;
        end else if (seg_q != SEG_IDLE) begin
            if (seg_last) begin
                cnt_q    <= '0;
                ps_pulse <= 1'b0;
                case (seg_q)
                    SEG_HI:  seg_q <= SEG_LO;
                    SEG_LO:  seg_q <= SEG_SETTLE;
                    default: seg_q <= SEG_IDLE;
                endcase
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pll_phase_tuner.sv
// Sweeps the PLL output through one period, records pass/fail per phase,
// picks the longest (possibly wrapping) passing window and parks at its centre.
module pll_phase_tuner
    import tuner_pkg::*;
#(
    parameter int         PS_STEPS      = 64,
    parameter int         SETTLE_CYCLES = 256,
    parameter int         PULSE_WIDTH   = 4,
    parameter logic [2:0] OUT_SEL       = 3'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    pll_phase_tuner_if.master  bus
);

    localparam int            PW       = calc_pw(PS_STEPS);
    localparam logic [PW:0]   FULL_LEN = (PW + 1)'(PS_STEPS);
    localparam logic [PW-1:0] LAST_POS = PW'(PS_STEPS - 1);
    localparam logic [PW-1:0] HALF_POS = PW'(PS_STEPS / 2);

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q;
    logic          pass_q;
    logic [PW-1:0] cur_start_q, best_start_q;
    logic [PW:0]   cur_len_q, best_len_q, lead_len_q;
    logic          sweep_done_q, resolved_q;
    logic [PW-1:0] remain_q;
    logic          centre_back_q;
    result_t       res_q;

    logic          lock_lost;
    logic          busy_w, done_w, test_req_w, step_go, step_dir;
    logic          ps_pulse_w, ps_dir_w, hi_end, lo_end, step_done;

    logic [PW-1:0] fin_start, centre, centre_steps, half_pos;
    logic [PW:0]   fin_len, cand_len, len_m1;
    logic          centre_back;
    logic          unused_res;

    assign lock_lost = !bus.pll_lock && (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (lock_lost) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (bus.start) state_d = bus.pll_lock ? S_TEST : S_DONE;
                S_TEST:         if (bus.test_ack) state_d = S_EVAL;
                S_EVAL:         state_d = S_STEP_HI;
                S_STEP_HI:      if (hi_end) state_d = S_STEP_LO;
                S_STEP_LO:      if (lo_end) state_d = S_SETTLE;
                S_SETTLE: begin
                    if (step_done) begin
                        if (!sweep_done_q)         state_d = S_TEST;
                        else if (!resolved_q)      state_d = S_RESOLVE;
                        else if (remain_q != '0)   state_d = S_CENTER;
                        else                       state_d = S_DONE;
                    end
                end
                S_RESOLVE:      state_d = (centre_steps != '0) ? S_CENTER : S_DONE;
                S_CENTER:       state_d = S_STEP_HI;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_w     = (state_q != S_IDLE) && (state_q != S_DONE);
        done_w     = (state_q == S_DONE);
        test_req_w = (state_q == S_TEST);
        step_go    = !lock_lost && ((state_q == S_EVAL) || (state_q == S_CENTER));
        step_dir   = (state_q == S_CENTER) ? centre_back_q : 1'b0;
    end

    // The trailing run is still open at RESOLVE; it merges with the leading
    // run when both ends of the period pass, and is compared last.
    always_comb begin
        fin_start = best_start_q;
        fin_len   = best_len_q;
        cand_len  = (lead_len_q != '0) ? (cur_len_q + lead_len_q) : cur_len_q;
        if (cur_len_q == FULL_LEN) begin
            fin_start = '0;
            fin_len   = FULL_LEN;
        end else if ((cur_len_q != '0) && (cand_len > best_len_q)) begin
            fin_start = cur_start_q;
            fin_len   = cand_len;
        end
        len_m1   = fin_len - (PW + 1)'(1);
        half_pos = PW'(len_m1 >> 1);
        centre   = fin_start + half_pos;
        if ((fin_len == '0) || (fin_len == FULL_LEN)) centre = '0;
        centre_back  = (centre > HALF_POS);
        centre_steps = centre_back ? ('0 - centre) : centre;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q         <= '0;
            pass_q        <= 1'b0;
            cur_start_q   <= '0;
            cur_len_q     <= '0;
            best_start_q  <= '0;
            best_len_q    <= '0;
            lead_len_q    <= '0;
            sweep_done_q  <= 1'b0;
            resolved_q    <= 1'b0;
            remain_q      <= '0;
            centre_back_q <= 1'b0;
            res_q         <= '0;
        end else if (lock_lost) begin
            res_q.fail <= 1'b1;
            pos_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start && bus.pll_lock) begin
                        pos_q         <= '0;
                        pass_q        <= 1'b0;
                        cur_start_q   <= '0;
                        cur_len_q     <= '0;
                        best_start_q  <= '0;
                        best_len_q    <= '0;
                        lead_len_q    <= '0;
                        sweep_done_q  <= 1'b0;
                        resolved_q    <= 1'b0;
                        remain_q      <= '0;
                        centre_back_q <= 1'b0;
                        res_q         <= '0;
                    end else if (bus.start) begin
                        res_q.fail <= 1'b1;
                    end
                end
                S_TEST: if (bus.test_ack) pass_q <= bus.test_pass;
                S_EVAL: begin
                    sweep_done_q <= (pos_q == LAST_POS);
                    if (pass_q) begin
                        if (cur_len_q == '0) cur_start_q <= pos_q;
                        cur_len_q <= cur_len_q + (PW + 1)'(1);
                    end else if (cur_len_q != '0) begin
                        if (cur_len_q > best_len_q) begin
                            best_start_q <= cur_start_q;
                            best_len_q   <= cur_len_q;
                        end
                        if (cur_start_q == '0) lead_len_q <= cur_len_q;
                        cur_len_q <= '0;
                    end
                end
                S_STEP_LO: if (lo_end) pos_q <= ps_dir_w ? (pos_q - PW'(1)) : (pos_q + PW'(1));
                S_RESOLVE: begin
                    res_q.best_phase <= MAX_PW'(centre);
                    res_q.window_len <= (MAX_PW + 1)'(fin_len);
                    res_q.fail       <= (fin_len == '0);
                    remain_q         <= centre_steps;
                    centre_back_q    <= centre_back;
                    resolved_q       <= 1'b1;
                end
                S_CENTER: remain_q <= remain_q - PW'(1);
                default: ;
            endcase
        end
    end

    ps_step_gen #(
        .PULSE_WIDTH   (PULSE_WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_step (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_go   (step_go),
        .dir       (step_dir),
        .abort     (lock_lost),
        .ps_pulse  (ps_pulse_w),
        .ps_dir    (ps_dir_w),
        .hi_end    (hi_end),
        .lo_end    (lo_end),
        .step_done (step_done)
    );

    assign unused_res = ^{res_q.best_phase[MAX_PW-1:PW], res_q.window_len[MAX_PW:PW+1]};

    assign bus.busy       = busy_w;
    assign bus.done       = done_w;
    assign bus.fail       = res_q.fail;
    assign bus.ps_sel     = OUT_SEL;
    assign bus.ps_dir     = ps_dir_w;
    assign bus.ps_pulse   = ps_pulse_w;
    assign bus.test_req   = test_req_w;
    assign bus.best_phase = res_q.best_phase[PW-1:0];
    assign bus.window_len = res_q.window_len[PW:0];

endmodule

// File: tb/tb_pll_phase_tuner.sv
// Directed bench for pll_phase_tuner: a pulse-counting PLL phase model plus a
// capture checker that acks three cycles after each request.
module tb_pll_phase_tuner;

    localparam int STEPS = 16;

    logic        clk;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    int          fwd_cnt = 0;
    int          bwd_cnt = 0;
    int          fwd_base = 0;
    int          bwd_base = 0;
    logic        pulse_prev = 1'b0;
    logic [15:0] pass_mask = 16'h0000;
    logic [3:0]  model_phase;

    pll_phase_tuner_if #(.PS_STEPS(STEPS)) bif ();

    pll_phase_tuner #(
        .PS_STEPS      (STEPS),
        .SETTLE_CYCLES (4),
        .PULSE_WIDTH   (2),
        .OUT_SEL       (3'd1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PLL model: each rising ps_pulse moves the phase one step in ps_dir.
    always @(negedge clk) begin
        if (bif.ps_pulse && !pulse_prev) begin
            if (bif.ps_dir) bwd_cnt = bwd_cnt + 1;
            else            fwd_cnt = fwd_cnt + 1;
        end
        pulse_prev = bif.ps_pulse;
    end

    initial begin
        bif.test_ack  = 1'b0;
        bif.test_pass = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.test_req) begin
                repeat (2) @(negedge clk);
                model_phase   = 4'((fwd_cnt - bwd_cnt) - (fwd_base - bwd_base));
                bif.test_ack  = 1'b1;
                bif.test_pass = pass_mask[model_phase];
                @(negedge clk);
                bif.test_ack  = 1'b0;
                bif.test_pass = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        fwd_base = fwd_cnt;
        bwd_base = bwd_cnt;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int mid_start);
        doReset();
        pass_mask = mask;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        checkOutput("busy_after_start", 32'(bif.busy), 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bif.done) break;
            bif.start = (cyc == mid_start);
            @(negedge clk);
        end
        bif.start = 1'b0;
        checkOutput("done_reached", 32'(bif.done), 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bif.start     = 1'b0;
        bif.pll_lock  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(bif.busy), 0);
        checkOutput("rst_done", 32'(bif.done), 0);
        checkOutput("rst_fail", 32'(bif.fail), 0);
        checkOutput("rst_ps_sel", 32'(bif.ps_sel), 1);
        checkOutput("rst_ps_pulse", 32'(bif.ps_pulse), 0);
        checkOutput("rst_ps_dir", 32'(bif.ps_dir), 0);
        checkOutput("rst_test_req", 32'(bif.test_req), 0);
        checkOutput("rst_best_phase", 32'(bif.best_phase), 0);
        checkOutput("rst_window_len", 32'(bif.window_len), 0);
        rst_n = 1'b1;

        $display("[TB] single window 5..9");
        applyStimulus(16'h03E0, -1);
        checkOutput("w59_fail", 32'(bif.fail), 0);
        checkOutput("w59_len", 32'(bif.window_len), 5);
        checkOutput("w59_best", 32'(bif.best_phase), 7);
        checkOutput("w59_fwd", fwd_cnt - fwd_base, 23);
        checkOutput("w59_bwd", bwd_cnt - bwd_base, 0);
        checkOutput("w59_busy", 32'(bif.busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("w59_done_held", 32'(bif.done), 1);

        $display("[TB] wrapping window 13..2");
        applyStimulus(16'hE007, -1);
        checkOutput("wrap_fail", 32'(bif.fail), 0);
        checkOutput("wrap_len", 32'(bif.window_len), 6);
        checkOutput("wrap_best", 32'(bif.best_phase), 15);
        checkOutput("wrap_fwd", fwd_cnt - fwd_base, 16);
        checkOutput("wrap_bwd", bwd_cnt - bwd_base, 1);

        $display("[TB] all positions fail");
        applyStimulus(16'h0000, -1);
        checkOutput("none_fail", 32'(bif.fail), 1);
        checkOutput("none_len", 32'(bif.window_len), 0);
        checkOutput("none_best", 32'(bif.best_phase), 0);
        checkOutput("none_pulses", (fwd_cnt - fwd_base) + (bwd_cnt - bwd_base), 16);

        $display("[TB] tied windows 2..4 and 8..10");
        applyStimulus(16'h071C, -1);
        checkOutput("tie_fail", 32'(bif.fail), 0);
        checkOutput("tie_len", 32'(bif.window_len), 3);
        checkOutput("tie_best", 32'(bif.best_phase), 3);
        checkOutput("tie_fwd", fwd_cnt - fwd_base, 19);

        $display("[TB] all positions pass");
        applyStimulus(16'hFFFF, -1);
        checkOutput("all_fail", 32'(bif.fail), 0);
        checkOutput("all_len", 32'(bif.window_len), 16);
        checkOutput("all_best", 32'(bif.best_phase), 0);
        checkOutput("all_pulses", (fwd_cnt - fwd_base) + (bwd_cnt - bwd_base), 16);

        $display("[TB] start while busy is ignored");
        applyStimulus(16'h03E0, 100);
        checkOutput("busy_start_len", 32'(bif.window_len), 5);
        checkOutput("busy_start_best", 32'(bif.best_phase), 7);
        checkOutput("busy_start_fwd", fwd_cnt - fwd_base, 23);

        $display("[TB] lock lost during settle at position 6");
        doReset();
        pass_mask = 16'hFFFF;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        for (int cyc = 0; cyc < 2000 && (fwd_cnt - fwd_base) < 6; cyc++) @(negedge clk);
        checkOutput("lock_reach_pos6", fwd_cnt - fwd_base, 6);
        for (int cyc = 0; cyc < 20 && bif.ps_pulse; cyc++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("lock_busy_before", 32'(bif.busy), 1);
        bif.pll_lock = 1'b0;
        @(negedge clk);
        checkOutput("lock_done", 32'(bif.done), 1);
        checkOutput("lock_fail", 32'(bif.fail), 1);
        checkOutput("lock_busy", 32'(bif.busy), 0);
        checkOutput("lock_ps_pulse", 32'(bif.ps_pulse), 0);
        checkOutput("lock_test_req", 32'(bif.test_req), 0);
        repeat (10) @(negedge clk);
        checkOutput("lock_no_more_pulses", (fwd_cnt - fwd_base) + (bwd_cnt - bwd_base), 6);
        bif.pll_lock = 1'b1;

        $display("[TB] start without lock");
        doReset();
        bif.pll_lock = 1'b0;
        bif.start    = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        checkOutput("nolock_done", 32'(bif.done), 1);
        checkOutput("nolock_fail", 32'(bif.fail), 1);
        checkOutput("nolock_busy", 32'(bif.busy), 0);
        repeat (20) @(negedge clk);
        checkOutput("nolock_pulses", (fwd_cnt - fwd_base) + (bwd_cnt - bwd_base), 0);
        bif.pll_lock = 1'b1;

        $display("[TB] async reset during a step pulse");
        doReset();
        pass_mask = 16'hFFFF;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        for (int cyc = 0; cyc < 200 && !bif.ps_pulse; cyc++) @(negedge clk);
        checkOutput("rstmid_saw_pulse", 32'(bif.ps_pulse), 1);
        checkOutput("rstmid_busy_before", 32'(bif.busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_ps_pulse", 32'(bif.ps_pulse), 0);
        checkOutput("rstmid_busy", 32'(bif.busy), 0);
        checkOutput("rstmid_done", 32'(bif.done), 0);
        checkOutput("rstmid_test_req", 32'(bif.test_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
